// File: rtl/id_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_stage
// Purpose  : Decode stage with register file, operand forwarding, load-use and
//            branch hazard detection, early branch resolution and ID/EX register.
// Revision : 1.0
// ============================================================================
module id_hazard_stage #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS),
  parameter int SIZE_OP       = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [SIZE-1:0]         i_instruction,
  input  logic [SIZE-1:0]         i_pc_plus4,
  input  logic                    i_flush,
  input  logic                    i_stall_ext,
  input  logic                    i_write_enable,
  input  logic [SIZE_REG_DIR-1:0] i_w_dir,
  input  logic [SIZE-1:0]         i_w_data,
  input  logic [SIZE_REG_DIR-1:0] i_rd_ex,
  input  logic                    i_reg_wr_ex,
  input  logic                    i_mem_read_ex,
  input  logic [SIZE_REG_DIR-1:0] i_rd_ex_mem,
  input  logic                    i_reg_wr_ex_mem,
  input  logic                    i_mem_read_ex_mem,
  input  logic [SIZE-1:0]         i_data_ex_mem,
  input  logic [SIZE_REG_DIR-1:0] i_rd_mem_wb,
  input  logic                    i_reg_wr_mem_wb,
  input  logic [SIZE-1:0]         i_data_mem_wb,
  output logic                    o_stall,
  output logic                    o_branch_taken,
  output logic [SIZE-1:0]         o_branch_target,
  output logic                    o_valid,
  output logic [SIZE_OP-1:0]      o_op,
  output logic [SIZE-1:0]         o_reg_A,
  output logic [SIZE-1:0]         o_reg_B,
  output logic [SIZE-1:0]         o_immediate,
  output logic [SIZE_REG_DIR-1:0] o_dir_rs,
  output logic [SIZE_REG_DIR-1:0] o_dir_rt,
  output logic [SIZE_REG_DIR-1:0] o_dir_rd
);

  localparam logic [SIZE_OP-1:0] c_OP_RTYPE = SIZE_OP'(0);
  localparam logic [SIZE_OP-1:0] c_OP_BEQ   = SIZE_OP'(4);
  localparam logic [SIZE_OP-1:0] c_OP_BNE   = SIZE_OP'(5);
  localparam logic [SIZE_OP-1:0] c_OP_ANDI  = SIZE_OP'(12);
  localparam logic [SIZE_OP-1:0] c_OP_ORI   = SIZE_OP'(13);
  localparam logic [SIZE_OP-1:0] c_OP_XORI  = SIZE_OP'(14);
  localparam logic [SIZE_OP-1:0] c_OP_SW    = SIZE_OP'(43);

  logic [SIZE-1:0]         r_regs [NUM_REGISTERS];
  logic                    r_valid;
  logic [SIZE_OP-1:0]      r_op;
  logic [SIZE-1:0]         r_reg_a;
  logic [SIZE-1:0]         r_reg_b;
  logic [SIZE-1:0]         r_imm;
  logic [SIZE_REG_DIR-1:0] r_rs;
  logic [SIZE_REG_DIR-1:0] r_rt;
  logic [SIZE_REG_DIR-1:0] r_rd;

  logic [SIZE_OP-1:0]      w_op;
  logic [SIZE_REG_DIR-1:0] w_rs;
  logic [SIZE_REG_DIR-1:0] w_rt;
  logic [SIZE_REG_DIR-1:0] w_rd;
  logic [15:0]             w_imm16;
  logic [SIZE-1:0]         w_imm;
  logic [SIZE-1:0]         w_a;
  logic [SIZE-1:0]         w_b;
  logic                    w_uses_rt;
  logic                    w_is_branch;
  logic                    w_load_use;
  logic                    w_branch_haz;
  logic                    w_stall;

  assign w_op    = SIZE_OP'(i_instruction[31:26]);
  assign w_rs    = SIZE_REG_DIR'(i_instruction[25:21]);
  assign w_rt    = SIZE_REG_DIR'(i_instruction[20:16]);
  assign w_rd    = SIZE_REG_DIR'(i_instruction[15:11]);
  assign w_imm16 = i_instruction[15:0];

  assign w_uses_rt   = (w_op == c_OP_RTYPE) || (w_op == c_OP_BEQ) ||
                       (w_op == c_OP_BNE)   || (w_op == c_OP_SW);
  assign w_is_branch = (w_op == c_OP_BEQ) || (w_op == c_OP_BNE);

  // Logical immediates are zero-extended; everything else sign-extends.
  assign w_imm = ((w_op == c_OP_ANDI) || (w_op == c_OP_ORI) || (w_op == c_OP_XORI))
               ? {{(SIZE-16){1'b0}}, w_imm16}
               : {{(SIZE-16){w_imm16[15]}}, w_imm16};

  // Load results in EX/MEM are not yet available, so only non-load EX/MEM forwards.
  function automatic logic [SIZE-1:0] f_operand(input logic [SIZE_REG_DIR-1:0] a);
    if (i_reg_wr_ex_mem && (i_rd_ex_mem != '0) && !i_mem_read_ex_mem && (i_rd_ex_mem == a))
      return i_data_ex_mem;
    else if (i_reg_wr_mem_wb && (i_rd_mem_wb != '0) && (i_rd_mem_wb == a))
      return i_data_mem_wb;
    else if (a == '0)
      return '0;
    else if (i_write_enable && (i_w_dir == a))
      return i_w_data;
    else
      return r_regs[a];
  endfunction

  function automatic logic f_branch_src_hit(input logic [SIZE_REG_DIR-1:0] a);
    return (a != '0) &&
           ((i_reg_wr_ex && (i_rd_ex == a)) || (i_mem_read_ex_mem && (i_rd_ex_mem == a)));
  endfunction

  always_comb begin
    w_a = f_operand(w_rs);
    w_b = f_operand(w_rt);
  end

  assign w_load_use = i_valid && i_mem_read_ex && i_reg_wr_ex && (i_rd_ex != '0) &&
                      ((i_rd_ex == w_rs) || (w_uses_rt && (i_rd_ex == w_rt)));
  assign w_branch_haz = i_valid && w_is_branch &&
                        (f_branch_src_hit(w_rs) || f_branch_src_hit(w_rt));
  assign w_stall = (w_load_use || w_branch_haz) && !i_flush;

  assign o_stall         = w_stall;
  assign o_branch_target = i_pc_plus4 + {w_imm[SIZE-3:0], 2'b00};
  assign o_branch_taken  = i_valid && !w_stall && !i_flush &&
                           (((w_op == c_OP_BEQ) && (w_a == w_b)) ||
                            ((w_op == c_OP_BNE) && (w_a != w_b)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGISTERS; i++) r_regs[i] <= '0;
    end else if (i_write_enable && (i_w_dir != '0)) begin
      r_regs[i_w_dir] <= i_w_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || i_flush || (!i_stall_ext && w_stall)) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_reg_a <= '0;
      r_reg_b <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (!i_stall_ext) begin
      r_valid <= i_valid;
      r_op    <= w_op;
      r_reg_a <= w_a;
      r_reg_b <= w_b;
      r_imm   <= w_imm;
      r_rs    <= w_rs;
      r_rt    <= w_rt;
      r_rd    <= w_rd;
    end
  end

  assign o_valid     = r_valid;
  assign o_op        = r_op;
  assign o_reg_A     = r_reg_a;
  assign o_reg_B     = r_reg_b;
  assign o_immediate = r_imm;
  assign o_dir_rs    = r_rs;
  assign o_dir_rt    = r_rt;
  assign o_dir_rd    = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_hazard_stage
// Purpose  : Scoreboard bench for id_hazard_stage (forwarding, hazards, reset).
// Revision : 1.0
// ============================================================================
module tb_id_hazard_stage;

  logic        clk, rst;
  logic        i_valid, i_flush, i_stall_ext;
  logic [31:0] i_instruction, i_pc_plus4;
  logic        i_write_enable;
  logic [4:0]  i_w_dir;
  logic [31:0] i_w_data;
  logic [4:0]  i_rd_ex, i_rd_ex_mem, i_rd_mem_wb;
  logic        i_reg_wr_ex, i_mem_read_ex;
  logic        i_reg_wr_ex_mem, i_mem_read_ex_mem, i_reg_wr_mem_wb;
  logic [31:0] i_data_ex_mem, i_data_mem_wb;
  logic        o_stall, o_branch_taken, o_valid;
  logic [31:0] o_branch_target, o_reg_A, o_reg_B, o_immediate;
  logic [5:0]  o_op;
  logic [4:0]  o_dir_rs, o_dir_rt, o_dir_rd;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, rd;
  } exp_t;
  exp_t sb[$];

  id_hazard_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_instruction(i_instruction),
    .i_pc_plus4(i_pc_plus4), .i_flush(i_flush), .i_stall_ext(i_stall_ext),
    .i_write_enable(i_write_enable), .i_w_dir(i_w_dir), .i_w_data(i_w_data),
    .i_rd_ex(i_rd_ex), .i_reg_wr_ex(i_reg_wr_ex), .i_mem_read_ex(i_mem_read_ex),
    .i_rd_ex_mem(i_rd_ex_mem), .i_reg_wr_ex_mem(i_reg_wr_ex_mem),
    .i_mem_read_ex_mem(i_mem_read_ex_mem), .i_data_ex_mem(i_data_ex_mem),
    .i_rd_mem_wb(i_rd_mem_wb), .i_reg_wr_mem_wb(i_reg_wr_mem_wb),
    .i_data_mem_wb(i_data_mem_wb), .o_stall(o_stall), .o_branch_taken(o_branch_taken),
    .o_branch_target(o_branch_target), .o_valid(o_valid), .o_op(o_op),
    .o_reg_A(o_reg_A), .o_reg_B(o_reg_B), .o_immediate(o_immediate),
    .o_dir_rs(o_dir_rs), .o_dir_rt(o_dir_rt), .o_dir_rd(o_dir_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_ctx();
    i_flush = 0; i_stall_ext = 0; i_write_enable = 0; i_w_dir = 0; i_w_data = 0;
    i_rd_ex = 0; i_reg_wr_ex = 0; i_mem_read_ex = 0;
    i_rd_ex_mem = 0; i_reg_wr_ex_mem = 0; i_mem_read_ex_mem = 0; i_data_ex_mem = 0;
    i_rd_mem_wb = 0; i_reg_wr_mem_wb = 0; i_data_mem_wb = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    i_valid = v; i_instruction = ins; i_pc_plus4 = pc;
  endtask

  task automatic push_cap(input logic v, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    exp_t e;
    e.v = v; e.op = op; e.a = a; e.b = b; e.imm = imm; e.rs = rs; e.rt = rt; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push_cap(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_valid"}, {31'd0, o_valid}, {31'd0, e.v});
      check_eq({tag, "_op"},    {26'd0, o_op},    {26'd0, e.op});
      check_eq({tag, "_A"},     o_reg_A,          e.a);
      check_eq({tag, "_B"},     o_reg_B,          e.b);
      check_eq({tag, "_imm"},   o_immediate,      e.imm);
      check_eq({tag, "_rs"},    {27'd0, o_dir_rs}, {27'd0, e.rs});
      check_eq({tag, "_rt"},    {27'd0, o_dir_rt}, {27'd0, e.rt});
      check_eq({tag, "_rd"},    {27'd0, o_dir_rd}, {27'd0, e.rd});
    end
  endtask

  task automatic chk_comb(input string tag, input logic st, input logic tk);
    #1;
    check_eq({tag, "_stall"}, {31'd0, o_stall}, {31'd0, st});
    check_eq({tag, "_taken"}, {31'd0, o_branch_taken}, {31'd0, tk});
  endtask

  initial begin
    rst = 0;
    clear_ctx();
    drive(0, 0, 0);
    #2;
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_A", o_reg_A, 32'd0);
    check_eq("rst_imm", o_immediate, 32'd0);
    @(posedge clk); #1;
    rst = 1;

    // Write r5, then read it back through an ADD
    i_write_enable = 1; i_w_dir = 5; i_w_data = 32'h12345678;
    push_bubble(); tick("wr_r5");
    i_write_enable = 0;
    drive(1, enc(0, 5, 0, 16'h3020), 32'h4);
    chk_comb("add_r5", 0, 0);
    push_cap(1, 0, 32'h12345678, 0, 32'h3020, 5, 0, 6); tick("add_r5");

    // Write-through bypass and r0 immunity
    i_write_enable = 1; i_w_dir = 7; i_w_data = 32'hA5;
    drive(1, enc(0, 7, 0, 16'h0800), 32'h8);
    push_cap(1, 0, 32'hA5, 0, 32'h800, 7, 0, 1); tick("bypass_r7");
    i_w_dir = 0; i_w_data = 32'hFF;
    drive(1, enc(0, 0, 7, 16'h0800), 32'hC);
    push_cap(1, 0, 0, 32'hA5, 32'h800, 0, 7, 1); tick("wr_r0");
    i_write_enable = 0;
    drive(1, enc(0, 0, 0, 16'h0000), 32'h10);
    push_cap(1, 0, 0, 0, 0, 0, 0, 0); tick("rd_r0");

    // Load-use: one bubble then capture; load in EX/MEM must not forward
    i_mem_read_ex = 1; i_reg_wr_ex = 1; i_rd_ex = 3;
    drive(1, enc(0, 3, 0, 16'h4000), 32'h14);
    chk_comb("ldu1", 1, 0);
    push_bubble(); tick("ldu1");
    clear_ctx();
    i_rd_ex_mem = 3; i_reg_wr_ex_mem = 1; i_mem_read_ex_mem = 1; i_data_ex_mem = 32'hBAD;
    i_rd_mem_wb = 3; i_reg_wr_mem_wb = 1; i_data_mem_wb = 32'hDEAD;
    chk_comb("ldu2", 0, 0);
    push_cap(1, 0, 32'hDEAD, 0, 32'h4000, 3, 0, 8); tick("ldu2");
    clear_ctx();

    // LW r4 then BEQ r4,r4: two stall cycles then taken
    i_mem_read_ex = 1; i_reg_wr_ex = 1; i_rd_ex = 4;
    drive(1, enc(4, 4, 4, 16'h0010), 32'h100);
    chk_comb("beq1", 1, 0);
    push_bubble(); tick("beq1");
    clear_ctx();
    i_rd_ex_mem = 4; i_reg_wr_ex_mem = 1; i_mem_read_ex_mem = 1; i_data_ex_mem = 32'h999;
    chk_comb("beq2", 1, 0);
    push_bubble(); tick("beq2");
    clear_ctx();
    i_rd_mem_wb = 4; i_reg_wr_mem_wb = 1; i_data_mem_wb = 32'h55;
    chk_comb("beq3", 0, 1);
    check_eq("beq3_target", o_branch_target, 32'h140);
    push_cap(1, 4, 32'h55, 32'h55, 32'h10, 4, 4, 0); tick("beq3");
    clear_ctx();

    // BNE with equal operands, negative offset
    drive(1, enc(5, 1, 2, 16'hFFFF), 32'h200);
    chk_comb("bne_nt", 0, 0);
    check_eq("bne_nt_target", o_branch_target, 32'h1FC);
    push_cap(1, 5, 0, 0, 32'hFFFFFFFF, 1, 2, 31); tick("bne_nt");
    // BNE taken, then same branch under flush
    i_rd_mem_wb = 1; i_reg_wr_mem_wb = 1; i_data_mem_wb = 32'h7;
    drive(1, enc(5, 1, 2, 16'h0001), 32'h300);
    chk_comb("bne_t", 0, 1);
    check_eq("bne_t_target", o_branch_target, 32'h304);
    push_cap(1, 5, 32'h7, 0, 32'h1, 1, 2, 0); tick("bne_t");
    i_flush = 1;
    chk_comb("bne_flush", 0, 0);
    push_bubble(); tick("bne_flush");
    clear_ctx();

    // Forwarding priority and immediate extension
    i_rd_ex_mem = 9; i_reg_wr_ex_mem = 1; i_data_ex_mem = 32'h11;
    i_rd_mem_wb = 9; i_reg_wr_mem_wb = 1; i_data_mem_wb = 32'h22;
    drive(1, enc(0, 9, 9, 16'h5000), 32'h400);
    push_cap(1, 0, 32'h11, 32'h11, 32'h5000, 9, 9, 10); tick("fwd_exmem");
    i_reg_wr_ex_mem = 0;
    drive(1, enc(0, 9, 0, 16'h5000), 32'h404);
    push_cap(1, 0, 32'h22, 0, 32'h5000, 9, 0, 10); tick("fwd_memwb");
    clear_ctx();
    i_mem_read_ex = 1; i_reg_wr_ex = 1; i_rd_ex = 1;
    drive(1, enc(13, 0, 1, 16'h8000), 32'h408);
    chk_comb("ori", 0, 0);
    push_cap(1, 13, 0, 0, 32'h00008000, 0, 1, 16); tick("ori");
    clear_ctx();
    drive(1, enc(8, 0, 1, 16'h8000), 32'h40C);
    push_cap(1, 8, 0, 0, 32'hFFFF8000, 0, 1, 16); tick("addi");

    // External stall holds; flush beats stall and masks hazards
    drive(1, enc(0, 7, 0, 16'h0800), 32'h410);
    push_cap(1, 0, 32'hA5, 0, 32'h800, 7, 0, 1); tick("pre_hold");
    i_stall_ext = 1;
    drive(1, enc(0, 0, 0, 16'h0000), 32'h414);
    push_cap(1, 0, 32'hA5, 0, 32'h800, 7, 0, 1); tick("hold");
    i_flush = 1; i_mem_read_ex = 1; i_reg_wr_ex = 1; i_rd_ex = 3;
    drive(1, enc(0, 3, 0, 16'h0000), 32'h418);
    chk_comb("flush_stall", 0, 0);
    push_bubble(); tick("flush_stall");
    clear_ctx();

    // Asynchronous reset between edges, asserted during a stall
    drive(1, enc(0, 7, 0, 16'h0800), 32'h41C);
    push_cap(1, 0, 32'hA5, 0, 32'h800, 7, 0, 1); tick("pre_rst");
    i_mem_read_ex = 1; i_reg_wr_ex = 1; i_rd_ex = 7;
    #2 rst = 0;
    #1;
    check_eq("arst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("arst_A", o_reg_A, 32'd0);
    check_eq("arst_imm", o_immediate, 32'd0);
    check_eq("arst_rs", {27'd0, o_dir_rs}, 32'd0);
    rst = 1;
    clear_ctx();
    chk_comb("post_rst", 0, 0);
    push_cap(1, 0, 0, 0, 32'h800, 7, 0, 1); tick("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_hazard_stage.md
ID_HAZARD_STAGE -- requirements
Module: id_hazard_stage

Interface
REQ-001 The module SHALL have parameter SIZE, default 32, meaning datapath width.
REQ-002 The module SHALL have parameter NUM_REGISTERS, default 32, meaning register-file depth.
REQ-003 The module SHALL have parameter SIZE_REG_DIR, default $clog2(NUM_REGISTERS), meaning register address width.
REQ-004 The module SHALL have parameter SIZE_OP, default 6, meaning opcode width.
REQ-005 The module SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_valid  in  1  i_instruction holds a real instruction
- i_instruction  in  SIZE  instruction from IF/ID
- i_pc_plus4  in  SIZE  PC+4 of that instruction
- i_flush  in  1  squash the instruction entering ID/EX
- i_stall_ext  in  1  downstream freeze, hold ID/EX
- i_write_enable, i_w_dir, i_w_data  in  1/SIZE_REG_DIR/SIZE  write-back port
- i_rd_ex, i_reg_wr_ex, i_mem_read_ex  in  SIZE_REG_DIR/1/1  instruction in EX
- i_rd_ex_mem, i_reg_wr_ex_mem, i_mem_read_ex_mem, i_data_ex_mem  in  SIZE_REG_DIR/1/1/SIZE  instruction in MEM
- i_rd_mem_wb, i_reg_wr_mem_wb, i_data_mem_wb  in  SIZE_REG_DIR/1/SIZE  instruction in WB
- o_stall  out  1  hold PC and IF/ID (combinational)
- o_branch_taken, o_branch_target  out  1/SIZE  IF redirect (combinational)
- o_valid, o_op, o_reg_A, o_reg_B, o_immediate, o_dir_rs, o_dir_rt, o_dir_rd  out  1/SIZE_OP/SIZE/SIZE/SIZE/SIZE_REG_DIR x3  registered ID/EX contents

Function
REQ-006 Fields SHALL be op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]; "uses_rt" SHALL be true for op 0, 4 (BEQ), 5 (BNE), 43 (SW).
REQ-007 Register file SHALL write i_w_data to i_w_dir on the clock edge when i_write_enable=1 and i_w_dir!=0; register 0 SHALL always read 0.
REQ-008 A read of the address written in the same cycle SHALL return i_w_data (write-through bypass).
REQ-009 Operand forwarding priority SHALL be EX/MEM (i_reg_wr_ex_mem, rd!=0, not a load), then MEM/WB (i_reg_wr_mem_wb, rd!=0), then register file.
REQ-010 Load-use hazard SHALL be i_valid & i_mem_read_ex & i_reg_wr_ex & i_rd_ex!=0 & (i_rd_ex==rs | (uses_rt & i_rd_ex==rt)).
REQ-011 Branch hazard SHALL be i_valid & op in {4,5} & a matching source (rs or rt, !=0) with either i_reg_wr_ex set on i_rd_ex, or i_mem_read_ex_mem set on i_rd_ex_mem.
REQ-012 o_stall SHALL equal (load-use | branch hazard) & !i_flush; a load followed by a dependent branch thus stalls exactly 2 cycles.
REQ-013 Immediate SHALL be zero-extended for op 12, 13, 14 (ANDI/ORI/XORI) and sign-extended otherwise.
REQ-014 o_branch_target SHALL be i_pc_plus4 + (immediate<<2) modulo 2^SIZE.
REQ-015 o_branch_taken SHALL be 1 only when i_valid & !o_stall & !i_flush & ((op==4 & A==B) | (op==5 & A!=B)) on forwarded operands.
REQ-016 ID/EX update on each edge, in priority order: i_flush -> bubble; else i_stall_ext -> hold all; else o_stall -> bubble; else capture decoded fields with o_valid=i_valid.
REQ-017 A bubble SHALL set o_valid=0, o_op=0, o_dir_rd=0 and all other ID/EX outputs to 0.
REQ-018 Latency from i_instruction to ID/EX outputs SHALL be 1 cycle absent stall/flush.

Reset
REQ-019 rst=0 SHALL immediately and asynchronously clear all registers and all ID/EX outputs to 0, o_valid=0, independent of clk.
REQ-020 Reset asserted mid-stall SHALL discard the stalled instruction; the first edge after release SHALL capture normally.

Verification
REQ-021 Write r5=0x12345678, then ADD rs=5 with no hazards -> next cycle o_reg_A=0x12345678, o_valid=1.
REQ-022 Same-cycle write r7=0xA5 and read r7 -> o_reg_A=0xA5; write to r0 with 0xFF -> r0 reads 0.
REQ-023 i_mem_read_ex=1, i_rd_ex=3, ID reads rs=3 -> o_stall=1 one cycle, ID/EX bubble (o_valid=0), then capture.
REQ-024 LW r4 in EX, then BEQ r4,r4 in ID -> o_stall=1 for 2 cycles, then o_branch_taken=1, target=pc_plus4+(imm<<2).
REQ-025 EX/MEM and MEM/WB both write r9 (0x11, 0x22) -> o_reg_A=0x11; ORI imm 0x8000 -> o_immediate=0x00008000, ADDI imm 0x8000 -> 0xFFFF8000.
REQ-026 i_flush=1 with i_stall_ext=1 -> bubble; rst=0 between edges -> outputs 0 before next edge.
